ifetch_prefetch_unit: RTL

- Parametrised next-generation instruction fetch stage.
- Generates the PC, issues reads to a synchronous instruction ROM with 1-cycle latency, and buffers returned words in a DEPTH-entry prefetch queue.
- Presents instructions to decode through a valid/ready handshake.
- Branch/jump/jr redirects from execute flush the queue and discard in-flight reads. Fetch is held idle after reset until the "enter" start strobe.

---
 rtl/ifetch_prefetch_unit_pkg.sv | 16 +
 rtl/ifetch_prefetch_unit_if.sv | 27 ++
 rtl/ifetch_prefetch_unit_queue.sv | 53 +++++
 rtl/ifetch_prefetch_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/ifetch_prefetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
// Package ifetch_pkg: instruction width, NOP encoding, FSM state encoding,
// PC increment and a saturating 32-bit add used by the optional perf counters.
package ifetch_pkg;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_RUN   = 1'b1;
  localparam int          PC_INC   = 4;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/ifetch_prefetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port, redirect input and decode handshake.
//   master : fetch unit side (drives imem_en/imem_addr and inst_*)
//   slave  : environment side (ROM, execute, decode)
interface ifetch_prefetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int IMEM_AW = 14
);
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst_data;
  logic [ADDR_W-1:0]  inst_pc;
  logic [ADDR_W-1:0]  inst_pc_plus4;

  modport master (
    output imem_en, imem_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_en, imem_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_prefetch_unit_queue.sv
// ifetch_queue: DEPTH x W synchronous FIFO, async active-high reset.
// Ports: clock, reset, push/pop/flush, wdata in; count, empty, head out.
// flush wins over push/pop. head is the combinational read of the oldest entry.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [W-1:0]           head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Credit-based issue guarantees a push never meets a full queue.
  always_ff @(posedge clock) begin
    if (!reset && !flush)
      assert (!(push && !pop && count == CW'(DEPTH)))
        else $error("ifetch_queue overflow");
  end
endmodule

// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: PC generation, 1-cycle-latency ROM reads and a
// DEPTH-entry prefetch queue feeding decode over valid/ready.
// Ports: clock, reset (async, active-high), enter (start strobe),
//   bus (ifetch_prefetch_unit_if.master): imem_*, redirect_*, inst_*.
// Optional: define IFETCH_PERF_CNT_EN to add perf_fetched / perf_flushed.
module ifetch_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              IMEM_AW  = 14,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  ifetch_prefetch_unit_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = INSTR_W + ADDR_W;

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              inflight, epoch, req_epoch;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic [QW-1:0]     q_head;
  logic [CW:0]       credit;
  logic              issue, flush, resp_ok, push, pop;

  // Slots already committed: queued entries plus the word on its way back.
  assign credit  = {1'b0, q_count} + (CW+1)'(inflight);
  assign issue   = (state == ST_RUN) && !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
  assign flush   = (state == ST_RUN) && bus.redirect_valid;
  // A response belongs to the current stream only if no redirect came in between.
  assign resp_ok = inflight && (req_epoch == epoch);
  assign push    = resp_ok && !flush;
  assign pop     = bus.inst_valid && bus.inst_ready && !flush;

  assign bus.imem_en       = issue;
  assign bus.imem_addr     = fetch_pc[IMEM_AW+1:2];
  assign bus.inst_valid    = !q_empty;
  assign bus.inst_data     = q_head[QW-1 -: INSTR_W];
  assign bus.inst_pc       = q_head[ADDR_W-1:0];
  // Forced to zero while reset is held so every decode-side output reads 0.
  assign bus.inst_pc_plus4 = reset ? '0 : q_head[ADDR_W-1:0] + ADDR_W'(PC_INC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      epoch     <= 1'b0;
      req_epoch <= 1'b0;
    end else begin
      if (state == ST_IDLE && enter) state <= ST_RUN;
      inflight <= issue;
      if (issue) begin
        req_pc    <= fetch_pc;
        req_epoch <= epoch;
      end
      if (bus.redirect_valid) fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
      else if (issue)         fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
      if (flush) epoch <= ~epoch;
    end
  end

  ifetch_queue #(.DEPTH(DEPTH), .W(QW)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({bus.imem_rdata, req_pc}),
    .count (q_count),
    .empty (q_empty),
    .head  (q_head)
  );

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop)   perf_fetched <= sat_add32(perf_fetched, 32'd1);
      if (flush) perf_flushed <= sat_add32(perf_flushed, 32'(q_count) + 32'(resp_ok));
    end
  end
`endif
endmodule
